// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encodings and default timing for the microwave controller
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COOKING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    // One timer decrement per second at a 50 MHz clock
    localparam int TICK_DIV_DEFAULT  = 50_000_000;
    localparam int DONE_SECS_DEFAULT = 3;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - shared cook-second prescaler and end-of-cook alarm counter
module tick_prescaler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DONE_SECS = 3,
    parameter int CW        = $clog2(TICK_DIV * DONE_SECS)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          load0,
    input  logic          hold,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam int TOTAL = TICK_DIV * DONE_SECS;

    // tick marks the last cycle of a second; the FSM reloads on it while cooking,
    // while in the alarm phase the count runs on to TOTAL-1
    assign tick = (count == CW'(TICK_DIV - 1));

    // Counter: load0 beats hold; free-running wrap only matters in the alarm phase
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (load0) begin
            count <= '0;
        end else if (!hold) begin
            if (count == CW'(TOTAL - 1)) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/microwave_control.sv
// rtl/microwave_control.sv - microwave timer control FSM driving timer, magnetron and buzzer
module microwave_control
    import microwave_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DONE_SECS = DONE_SECS_DEFAULT
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start_n,
    input  logic       stop_n,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_en,
    output logic       timer_clearn,
    output logic       mag_on,
    output logic       buzzer,
    output logic [1:0] state
);

    localparam int TOTAL = TICK_DIV * DONE_SECS;
    localparam int CW    = $clog2(TOTAL);

    state_t        cur;
    logic [1:0]    start_sync;
    logic [1:0]    stop_sync;
    logic          start_prev;
    logic          stop_prev;
    logic          press_start;
    logic          press_stop;
    logic          load0;
    logic          hold;
    logic          tick;
    logic [CW-1:0] count;
    logic          done_expired;

    assign state = cur;

    // Two-flop synchronisers plus a delayed copy for falling-edge detection;
    // everything resets to the released level so no spurious press follows reset
    always_ff @(posedge clock) begin
        if (clear) begin
            start_sync <= 2'b11;
            stop_sync  <= 2'b11;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
        end else begin
            start_sync <= {start_sync[0], start_n};
            stop_sync  <= {stop_sync[0], stop_n};
            start_prev <= start_sync[1];
            stop_prev  <= stop_sync[1];
        end
    end

    assign press_start  = start_prev & ~start_sync[1];
    assign press_stop   = stop_prev & ~stop_sync[1];
    assign done_expired = (count == CW'(TOTAL - 1));

    // Prescaler control: the count freezes on any cycle that leaves or stays out of
    // COOKING, including the resume edge, so a resumed second finishes where it stopped
    always_comb begin
        load0 = 1'b0;
        hold  = 1'b1;
        case (cur)
            IDLE: begin
                load0 = press_start & door_closed & ~timer_zero & ~press_stop;
            end
            COOKING: begin
                if (timer_zero) begin
                    load0 = 1'b1;
                end else if (door_closed && !press_stop) begin
                    hold  = 1'b0;
                    load0 = tick;
                end
            end
            PAUSED: begin
                hold = 1'b1;
            end
            DONE: begin
                hold = 1'b0;
            end
            default: begin
                hold = 1'b1;
            end
        endcase
    end

    tick_prescaler #(
        .TICK_DIV  (TICK_DIV),
        .DONE_SECS (DONE_SECS),
        .CW        (CW)
    ) u_prescaler (
        .clock (clock),
        .clear (clear),
        .load0 (load0),
        .hold  (hold),
        .tick  (tick),
        .count (count)
    );

    // Main FSM; outputs are registered and change on the same edge as the state
    always_ff @(posedge clock) begin
        if (clear) begin
            cur          <= IDLE;
            timer_en     <= 1'b0;
            timer_clearn <= 1'b1;
            mag_on       <= 1'b0;
            buzzer       <= 1'b0;
        end else begin
            timer_en     <= 1'b0;
            timer_clearn <= 1'b1;
            case (cur)
                IDLE: begin
                    if (press_stop) begin
                        timer_clearn <= 1'b0;
                    end else if (press_start && door_closed && !timer_zero) begin
                        cur    <= COOKING;
                        mag_on <= 1'b1;
                    end
                end
                COOKING: begin
                    // A zero timer is never decremented again, so no 0 -> 5 wrap
                    if (timer_zero) begin
                        cur    <= DONE;
                        mag_on <= 1'b0;
                        buzzer <= 1'b1;
                    end else if (!door_closed || press_stop) begin
                        cur    <= PAUSED;
                        mag_on <= 1'b0;
                    end else begin
                        timer_en <= tick;
                    end
                end
                PAUSED: begin
                    if (press_stop) begin
                        cur          <= IDLE;
                        timer_clearn <= 1'b0;
                    end else if (press_start && door_closed) begin
                        cur    <= COOKING;
                        mag_on <= 1'b1;
                    end
                end
                DONE: begin
                    if (press_stop || !door_closed || done_expired) begin
                        cur    <= IDLE;
                        buzzer <= 1'b0;
                    end
                end
                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_control.sv
// tb/tb_microwave_control.sv - directed self-checking bench for microwave_control
module tb_microwave_control;

    logic       clock;
    logic       clear;
    logic       start_n;
    logic       stop_n;
    logic       door_closed;
    logic       timer_zero;
    logic       timer_en;
    logic       timer_clearn;
    logic       mag_on;
    logic       buzzer;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;

    microwave_control #(
        .TICK_DIV  (4),
        .DONE_SECS (2)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .start_n      (start_n),
        .stop_n       (stop_n),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .timer_en     (timer_en),
        .timer_clearn (timer_clearn),
        .mag_on       (mag_on),
        .buzzer       (buzzer),
        .state        (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Hold the selected buttons low until the third edge, where the press takes effect
    task automatic press(input logic st, input logic sp);
        start_n = ~st;
        stop_n  = ~sp;
        step(3);
        start_n = 1'b1;
        stop_n  = 1'b1;
    endtask

    initial begin
        logic saw_en;
        clear       = 1'b1;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        door_closed = 1'b1;
        timer_zero  = 1'b0;
        step(2);
        check("rst_state", state, 2'b00);
        check("rst_ten", timer_en, 1'b0);
        check("rst_clearn", timer_clearn, 1'b1);
        check("rst_mag", mag_on, 1'b0);
        check("rst_buzz", buzzer, 1'b0);
        start_n = 1'b1;
        stop_n  = 1'b1;
        clear   = 1'b0;
        step(5);
        check("post_rst_state", state, 2'b00);
        check("post_rst_clearn", timer_clearn, 1'b1);

        // Normal cook from 00:02
        press(1'b1, 1'b0);
        check("cook_state", state, 2'b01);
        check("cook_mag", mag_on, 1'b1);
        step(3);
        check("ten_before_first", timer_en, 1'b0);
        step(1);
        check("ten_first", timer_en, 1'b1);
        step(1);
        check("ten_after_first", timer_en, 1'b0);
        step(3);
        check("ten_second", timer_en, 1'b1);
        step(1);
        timer_zero = 1'b1;
        step(1);
        check("done_state", state, 2'b11);
        check("done_buzz", buzzer, 1'b1);
        check("done_mag", mag_on, 1'b0);
        step(7);
        check("done_hold_state", state, 2'b11);
        check("done_hold_buzz", buzzer, 1'b1);
        step(1);
        check("done_exit_state", state, 2'b00);
        check("done_exit_buzz", buzzer, 1'b0);
        timer_zero = 1'b0;

        // Door opened mid-second, then resume
        press(1'b1, 1'b0);
        check("door_cook_state", state, 2'b01);
        step(6);
        door_closed = 1'b0;
        step(1);
        check("door_pause_state", state, 2'b10);
        check("door_pause_mag", mag_on, 1'b0);
        check("door_pause_ten", timer_en, 1'b0);
        door_closed = 1'b1;
        press(1'b1, 1'b0);
        check("resume_state", state, 2'b01);
        check("resume_mag", mag_on, 1'b1);
        step(1);
        check("resume_ten_early", timer_en, 1'b0);
        step(1);
        check("resume_ten", timer_en, 1'b1);

        // Stop in COOKING pauses, stop in PAUSED clears, stop in IDLE clears again
        press(1'b0, 1'b1);
        check("stop_cook_state", state, 2'b10);
        check("stop_cook_clearn", timer_clearn, 1'b1);
        step(3);
        press(1'b0, 1'b1);
        check("stop_pause_state", state, 2'b00);
        check("stop_pause_clearn", timer_clearn, 1'b0);
        step(1);
        check("stop_pause_clearn_end", timer_clearn, 1'b1);
        step(2);
        press(1'b0, 1'b1);
        check("stop_idle_state", state, 2'b00);
        check("stop_idle_clearn", timer_clearn, 1'b0);
        step(1);
        check("stop_idle_clearn_end", timer_clearn, 1'b1);
        step(2);

        // Start refused with a zero timer or an open door
        timer_zero = 1'b1;
        saw_en = 1'b0;
        press(1'b1, 1'b0);
        check("start_zero_state", state, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step(1);
            saw_en = saw_en | timer_en;
        end
        check("start_zero_ten", saw_en, 1'b0);
        timer_zero  = 1'b0;
        door_closed = 1'b0;
        press(1'b1, 1'b0);
        check("start_door_state", state, 2'b00);
        check("start_door_mag", mag_on, 1'b0);
        door_closed = 1'b1;
        step(3);

        // Zero and door-open in the same cycle: zero wins; open door then ends DONE
        press(1'b1, 1'b0);
        check("prio_cook_state", state, 2'b01);
        step(1);
        timer_zero  = 1'b1;
        door_closed = 1'b0;
        step(1);
        check("prio_state", state, 2'b11);
        check("prio_buzz", buzzer, 1'b1);
        step(1);
        check("done_door_state", state, 2'b00);
        check("done_door_buzz", buzzer, 1'b0);
        timer_zero  = 1'b0;
        door_closed = 1'b1;
        step(1);

        // Start and stop together in PAUSED: stop wins
        press(1'b1, 1'b0);
        check("both_cook_state", state, 2'b01);
        door_closed = 1'b0;
        step(1);
        check("both_pause_state", state, 2'b10);
        door_closed = 1'b1;
        step(3);
        press(1'b1, 1'b1);
        check("both_state", state, 2'b00);
        check("both_clearn", timer_clearn, 1'b0);
        step(1);
        check("both_clearn_end", timer_clearn, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
